monopix_ro_responder: RTL and testbench
=======================================

MONOPIX_RO_RESPONDER -- requirements
Module: monopix_ro_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of queued hit words (power of two, 2..32).
REQ-002 SHALL have parameter DATA_DLY, default 1, cycles from first sampled read high to first data bit (1..4).
REQ-003 SHALL have port clk_bx  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high; clears all state.
REQ-005 SHALL have port hit_valid  input  1  push request, one hit per cycle.
REQ-006 SHALL have port hit_col  input  6  column address.
REQ-007 SHALL have port hit_row  input  9  row address.
REQ-008 SHALL have port hit_le  input  6  leading-edge timestamp, binary.
REQ-009 SHALL have port hit_te  input  6  trailing-edge timestamp, binary.
REQ-010 SHALL have port freeze  input  1  controller freeze; holds token.
REQ-011 SHALL have port read  input  1  controller read strobe; rising edge requests one word.
REQ-012 SHALL have port token  output  1  registered; word available.
REQ-013 SHALL have port data_out  output  1  registered serial data, MSB first.
REQ-014 SHALL have port busy  output  1  high while a word is being serialized.
REQ-015 SHALL have port empty_read  output  1  one-cycle pulse on read request with empty FIFO.
REQ-016 SHALL have port ovf_cnt  output  8  count of dropped hits, saturating at 255.

Function
REQ-017 SHALL form word[26:0] = {col[5:0], row[8:0], le_gray[5:0], te_gray[5:0]} at push, gray = bin ^ (bin >> 1).
REQ-018 SHALL accept a push when FIFO not full, or when full and a pop occurs in the same cycle.
REQ-019 SHALL drop a push to a full FIFO without a same-cycle pop and increment ovf_cnt (saturating at 255).
REQ-020 SHALL detect a read request as read high this cycle and low the previous cycle (rising edge only).
REQ-021 SHALL use state machine IDLE, WAIT, SHIFT; reset state IDLE.
REQ-022 IDLE: on a read request, latch head word into the shift register, pop if non-empty, go to WAIT, or straight to SHIFT when DATA_DLY=1.
REQ-023 WAIT: count DATA_DLY-1 cycles, then go to SHIFT.
REQ-024 SHIFT: drive word[26-k] on data_out in the k-th SHIFT cycle, k=0..26; after k=26 go to IDLE, data_out=0.
REQ-025 Net timing: first bit (bit 26) on data_out exactly DATA_DLY cycles after the cycle read is first sampled high; 27 consecutive bits.
REQ-026 SHALL ignore read requests in WAIT or SHIFT: no pop, no latch, no pulse.
REQ-027 Read request with empty FIFO: serialize 27'h0, no pop, empty_read pulses high in the request cycle+1.
REQ-028 token SHALL be registered: next value = FIFO non-empty when freeze low; hold current value when freeze high.
REQ-029 Pushes during freeze SHALL be accepted; token reflects them only after freeze falls.
REQ-030 busy SHALL be high in WAIT and SHIFT, low in IDLE.
REQ-031 Pointer wrap-around at FIFO_DEPTH SHALL preserve order; occupancy counter width log2(FIFO_DEPTH)+1.

Reset
REQ-032 On reset high, token=0, data_out=0, busy=0, empty_read=0, ovf_cnt=0, state IDLE, FIFO empty, read-edge register 0, asynchronously.
REQ-033 Reset asserted mid-SHIFT SHALL abort serialization; the latched word is lost; no partial bits after release.
REQ-034 First read request SHALL be recognized no earlier than the second clock edge after reset release.

Verification
REQ-035 Push col=5,row=100,le=3,te=10; freeze=0 -> token=1 next cycle; read pulse -> serial word 27'h0A6408F MSB first starting DATA_DLY cycles later; token=0 after pop.
REQ-036 Push 9 hits while frozen, depth 8 -> ovf_cnt=1, token stays 0 until freeze falls, then 1; 8 reads return hits 0..7 in order.
REQ-037 Read with empty FIFO -> empty_read one pulse, data_out all 0 for 27 cycles, busy high 27+DATA_DLY-1 cycles.
REQ-038 Second read rising edge during SHIFT -> ignored; exactly one pop; FIFO occupancy decrements by 1.
REQ-039 Full FIFO, push and read request same cycle -> push accepted, ovf_cnt unchanged, occupancy stays 8.
REQ-040 Reset at SHIFT bit 10 -> data_out=0 immediately, token=0, busy=0; after release a new push/read returns the new word only.

Source files
------------

// File: rtl/monopix_ro_responder.sv
// ---------------------------------------------------------------------------
// monopix_ro_responder
//
// Pixel-matrix readout responder. Hits are Gray-coded and queued into a small
// FIFO; a controller watches `token`, raises `read`, and receives one 27-bit
// word serially on `data_out`, MSB first, DATA_DLY cycles after the request.
//
// Ports
//   clk_bx      in   single clock, rising edge
//   reset       in   asynchronous, active-high
//   hit_valid   in   push one hit this cycle
//   hit_col     in   [5:0] column address
//   hit_row     in   [8:0] row address
//   hit_le      in   [5:0] leading-edge timestamp (binary)
//   hit_te      in   [5:0] trailing-edge timestamp (binary)
//   freeze      in   holds token at its current value
//   read        in   rising edge requests one word
//   token       out  registered "word available"
//   data_out    out  registered serial data, MSB first
//   busy        out  high while a word is being delivered
//   empty_read  out  one-cycle pulse after a request against an empty FIFO
//   ovf_cnt     out  [7:0] dropped-hit count, saturating at 255
// ---------------------------------------------------------------------------
module monopix_ro_responder #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_DLY   = 1
) (
  input  logic       clk_bx,
  input  logic       reset,
  input  logic       hit_valid,
  input  logic [5:0] hit_col,
  input  logic [8:0] hit_row,
  input  logic [5:0] hit_le,
  input  logic [5:0] hit_te,
  input  logic       freeze,
  input  logic       read,
  output logic       token,
  output logic       data_out,
  output logic       busy,
  output logic       empty_read,
  output logic [7:0] ovf_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  // Last WAIT count value; WAIT is skipped entirely when DATA_DLY is 1.
  localparam logic [4:0] WAIT_LAST = 5'((DATA_DLY > 1) ? DATA_DLY - 2 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHIFT} state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [26:0]     shreg_q, shreg_d;
  logic            data_out_q, data_out_d;
  logic            empty_read_q, empty_read_d;
  logic            token_q;
  logic [7:0]      ovf_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            read_prev_q;
  logic            armed_q;
  logic [26:0]     mem_q [FIFO_DEPTH];

  logic            fifo_empty, fifo_full;
  logic            req, pop, push, drop;
  logic [26:0]     push_word;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

  // armed_q keeps a read held high across reset release from being taken on
  // the very first edge; the edge detector then needs one more low cycle.
  assign req = read & ~read_prev_q & armed_q;

  assign push_word = {hit_col, hit_row, hit_le ^ (hit_le >> 1), hit_te ^ (hit_te >> 1)};
  // A full FIFO still takes a hit when the same cycle frees a slot.
  assign push = hit_valid & (~fifo_full | pop);
  assign drop = hit_valid & fifo_full & ~pop;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    data_out_d   = 1'b0;
    empty_read_d = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          shreg_d      = fifo_empty ? 27'h0 : mem_q[rd_ptr_q];
          pop          = ~fifo_empty;
          empty_read_d = fifo_empty;
          cnt_d        = 5'd0;
          state_d      = (DATA_DLY == 1) ? ST_SHIFT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 5'd0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_SHIFT: begin
        data_out_d = shreg_q[26];
        shreg_d    = {shreg_q[25:0], 1'b0};
        if (cnt_q == 5'd26) begin
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      shreg_q      <= 27'h0;
      data_out_q   <= 1'b0;
      empty_read_q <= 1'b0;
      token_q      <= 1'b0;
      ovf_q        <= 8'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      read_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      empty_read_q <= empty_read_d;
      token_q      <= freeze ? token_q : ~fifo_empty;
      read_prev_q  <= read;
      armed_q      <= 1'b1;
      if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is not reset; occupancy and pointers alone decide
  // which entries are valid, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk_bx) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign token      = token_q;
  assign data_out   = data_out_q;
  assign busy       = (state_q != ST_IDLE);
  assign empty_read = empty_read_q;
  assign ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_monopix_ro_responder.sv
// ---------------------------------------------------------------------------
// tb_monopix_ro_responder
//
// Self-checking bench. A transaction-level model (queue of words, pending
// serial-bit schedule, busy-cycle budget) predicts every output each cycle;
// directed steps cover the documented scenarios, then a randomized phase.
// ---------------------------------------------------------------------------
module tb_monopix_ro_responder;

  localparam int DEPTH = 8;
  localparam int DLY   = 2;

  logic       clk_bx = 1'b0;
  logic       reset  = 1'b1;
  logic       hit_valid = 1'b0;
  logic [5:0] hit_col = '0;
  logic [8:0] hit_row = '0;
  logic [5:0] hit_le  = '0;
  logic [5:0] hit_te  = '0;
  logic       freeze = 1'b0;
  logic       read   = 1'b0;
  logic       token, data_out, busy, empty_read;
  logic [7:0] ovf_cnt;

  int n_checks = 0;
  int n_errors = 0;

  monopix_ro_responder #(.FIFO_DEPTH(DEPTH), .DATA_DLY(DLY)) dut (
    .clk_bx(clk_bx), .reset(reset), .hit_valid(hit_valid),
    .hit_col(hit_col), .hit_row(hit_row), .hit_le(hit_le), .hit_te(hit_te),
    .freeze(freeze), .read(read), .token(token), .data_out(data_out),
    .busy(busy), .empty_read(empty_read), .ovf_cnt(ovf_cnt)
  );

  always #5 clk_bx = ~clk_bx;

  // ---------------- reference model ----------------
  logic [26:0] mq[$];
  bit          msched[$];
  int          m_ovf;
  int          m_busy_left;
  logic        m_tok, m_er, m_do, m_prev, m_armed;

  function automatic logic [26:0] mkword(logic [5:0] c, logic [8:0] r,
                                         logic [5:0] l, logic [5:0] t);
    return {c, r, l ^ (l >> 1), t ^ (t >> 1)};
  endfunction

  task automatic model_reset();
    mq.delete();
    msched.delete();
    m_ovf = 0; m_busy_left = 0;
    m_tok = 0; m_er = 0; m_do = 0; m_prev = 0; m_armed = 0;
  endtask

  task automatic model_edge();
    int occ;
    bit req, pop;
    logic [26:0] w;
    occ = mq.size();
    req = read && !m_prev && m_armed && (m_busy_left == 0);
    pop = req && (occ > 0);
    w   = pop ? mq[0] : 27'h0;
    if (!freeze) m_tok = (occ > 0);
    m_er = req && (occ == 0);
    if (m_busy_left > 0) m_busy_left--;
    m_do = 1'b0;
    if (msched.size() > 0) m_do = msched.pop_front();
    if (req) begin
      m_busy_left = 26 + DLY;
      for (int i = 0; i < DLY - 1; i++) msched.push_back(1'b0);
      for (int k = 26; k >= 0; k--) msched.push_back(w[k]);
    end
    if (pop) void'(mq.pop_front());
    if (hit_valid) begin
      if (mq.size() < DEPTH) mq.push_back(mkword(hit_col, hit_row, hit_le, hit_te));
      else if (m_ovf < 255) m_ovf++;
    end
    m_prev  = read;
    m_armed = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("token",      {31'd0, token},      {31'd0, m_tok});
    check("data_out",   {31'd0, data_out},   {31'd0, m_do});
    check("busy",       {31'd0, busy},       {31'd0, (m_busy_left > 0)});
    check("empty_read", {31'd0, empty_read}, {31'd0, m_er});
    check("ovf_cnt",    {24'd0, ovf_cnt},    m_ovf);
  endtask

  // One clock: model follows the inputs present at the edge, outputs are
  // compared on the falling edge. Inputs change only after this returns.
  task automatic step();
    @(posedge clk_bx);
    if (reset) model_reset(); else model_edge();
    @(negedge clk_bx);
    check_outputs();
  endtask

  task automatic push_hit(input logic [5:0] c, input logic [8:0] r,
                          input logic [5:0] l, input logic [5:0] t);
    hit_valid = 1; hit_col = c; hit_row = r; hit_le = l; hit_te = t;
    step();
    hit_valid = 0;
  endtask

  // Issues one read request (any hit inputs set by the caller are applied in
  // the same cycle) and collects the 27 serial bits.
  task automatic read_word(output logic [26:0] w);
    logic [26:0] acc;
    acc = '0;
    read = 1; step(); read = 0; hit_valid = 0;
    for (int i = 0; i < DLY - 1; i++) step();
    for (int i = 0; i < 27; i++) begin
      step();
      acc = {acc[25:0], data_out};
    end
    w = acc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [26:0] w, a_word, b_word, e_word;
    logic [26:0] exp_words[$];
    logic [7:0]  ovf_before;
    int          busy_cycles;

    model_reset();
    #1;
    check_outputs();                       // asynchronous reset state
    step(); step();
    reset = 0;

    // Read held high across reset release must not be taken.
    read = 1; step(); step(); read = 0; step();
    check("no_early_read", {31'd0, busy}, 32'd0);

    // Single word, known encoding.
    push_hit(6'd5, 9'd100, 6'd3, 6'd10);
    step();
    check("token_after_push", {31'd0, token}, 32'd1);
    read_word(w);
    check("word_0A6408F", {5'd0, w}, 32'h0A6408F);
    step();
    check("token_after_pop", {31'd0, token}, 32'd0);

    // Nine hits while frozen into depth 8.
    freeze = 1;
    for (int i = 0; i < 9; i++) begin
      push_hit(6'(i), 9'(i * 3 + 1), 6'(i), 6'(63 - i));
      if (i < 8) exp_words.push_back(mkword(6'(i), 9'(i * 3 + 1), 6'(i), 6'(63 - i)));
    end
    step();
    check("ovf_one", {24'd0, ovf_cnt}, 32'd1);
    check("token_frozen", {31'd0, token}, 32'd0);
    freeze = 0;
    step();
    check("token_unfrozen", {31'd0, token}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      read_word(w);
      check($sformatf("order_%0d", i), {5'd0, w}, {5'd0, exp_words[i]});
    end

    // Empty read.
    read = 1; step(); read = 0;
    check("empty_read_pulse", {31'd0, empty_read}, 32'd1);
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 34; i++) begin
      step();
      if (busy) busy_cycles++;
    end
    check("empty_busy_len", busy_cycles, 27 + DLY - 1);

    // Second rising edge of read during SHIFT is ignored.
    a_word = mkword(6'd63, 9'd511, 6'd0, 6'd63);
    b_word = mkword(6'd1, 9'd2, 6'd45, 6'd17);
    push_hit(6'd63, 9'd511, 6'd0, 6'd63);
    push_hit(6'd1, 9'd2, 6'd45, 6'd17);
    read = 1; step(); read = 0;
    for (int i = 0; i < DLY - 1; i++) step();
    w = '0;
    for (int i = 0; i < 27; i++) begin
      read = (i == 5);
      step();
      w = {w[25:0], data_out};
    end
    read = 0;
    check("first_of_two", {5'd0, w}, {5'd0, a_word});
    read_word(w);
    check("second_of_two", {5'd0, w}, {5'd0, b_word});
    read_word(w);
    check("drained", {5'd0, w}, 32'd0);

    // Full FIFO with simultaneous push and read request.
    exp_words.delete();
    for (int i = 0; i < 8; i++) begin
      push_hit(6'(10 + i), 9'(200 + i), 6'(i * 7), 6'(i * 5));
      exp_words.push_back(mkword(6'(10 + i), 9'(200 + i), 6'(i * 7), 6'(i * 5)));
    end
    ovf_before = ovf_cnt;
    hit_valid = 1; hit_col = 6'd33; hit_row = 9'd333; hit_le = 6'd21; hit_te = 6'd42;
    exp_words.push_back(mkword(6'd33, 9'd333, 6'd21, 6'd42));
    read_word(w);
    check("full_push_word0", {5'd0, w}, {5'd0, exp_words[0]});
    check("full_push_ovf", {24'd0, ovf_cnt}, {24'd0, ovf_before});
    for (int i = 1; i < 9; i++) begin
      read_word(w);
      check($sformatf("full_push_word%0d", i), {5'd0, w}, {5'd0, exp_words[i]});
    end

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      hit_valid = ($urandom_range(0, 2) == 0);
      hit_col   = 6'($urandom);
      hit_row   = 9'($urandom);
      hit_le    = 6'($urandom);
      hit_te    = 6'($urandom);
      read      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      step();
    end
    hit_valid = 0; read = 0; freeze = 0;

    // Overflow saturation.
    for (int i = 0; i < 270; i++) push_hit(6'($urandom), 9'($urandom), 6'($urandom), 6'($urandom));
    check("ovf_saturated", {24'd0, ovf_cnt}, 32'd255);

    // Reset in the middle of SHIFT.
    step();
    read = 1; step(); read = 0;
    for (int i = 0; i < DLY - 1 + 10; i++) step();
    reset = 1;
    #1;
    model_reset();
    check("rst_data_out", {31'd0, data_out}, 32'd0);
    check("rst_token", {31'd0, token}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {24'd0, ovf_cnt}, 32'd0);
    @(negedge clk_bx);
    step();
    reset = 0;
    step(); step();
    e_word = mkword(6'd42, 9'd300, 6'd13, 6'd50);
    push_hit(6'd42, 9'd300, 6'd13, 6'd50);
    read_word(w);
    check("post_rst_word", {5'd0, w}, {5'd0, e_word});
    read_word(w);
    check("post_rst_empty", {5'd0, w}, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
